// File: rtl/serial_gates_100_reduce.sv
// serial_gates_100_reduce
// Receive-side reduction engine for 100-bit operands delivered as 25 four-bit
// beats (beat 0 first) on a val/rdy stream. The AND and OR of all 100 bits are
// accumulated beat by beat. The AND, NAND, OR and NOR results are presented on
// a val/rdy output stream.
// Optional feature: define SERIAL_GATES_100_REDUCE_COUNT_EN to add the
// population-count accumulator and the out_count port.
module serial_gates_100_reduce (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [3:0] in_,
    output logic       out_val,
    input  logic       out_rdy,
    output logic       out_and,
    output logic       out_nand,
    output logic       out_or,
    output logic       out_nor
`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
    ,
    output logic [6:0] out_count
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [4:0] LAST_BEAT = 5'd24;

    state_t     state_q;
    logic [4:0] cnt_q;
    logic       and_acc_q;
    logic       or_acc_q;
    logic       beat_fire;

    // A beat is taken only while accumulating; data is ignored otherwise.
    assign beat_fire = in_val && in_rdy;

`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
    logic [6:0] cnt_acc_q;
    logic [2:0] beat_ones;

    // Number of set bits in the current beat (0..4).
    assign beat_ones = {2'b00, in_[0]} + {2'b00, in_[1]}
                     + {2'b00, in_[2]} + {2'b00, in_[3]};

    // The maximum total is 100, so 7 bits never overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_acc_q <= 7'd0;
        end else if (state_q == ACCUM) begin
            if (beat_fire) begin
                cnt_acc_q <= cnt_acc_q + {4'b0000, beat_ones};
            end
        end else if (out_rdy) begin
            cnt_acc_q <= 7'd0;
        end
    end
`endif

    // Control FSM with the beat counter and the AND/OR accumulators.
    // The wrap at the last beat (24 -> 0) is explicit.
    // Results are cleared when the output is transferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACCUM;
            cnt_q     <= 5'd0;
            and_acc_q <= 1'b1;
            or_acc_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat_fire) begin
                        and_acc_q <= and_acc_q & (&in_);
                        or_acc_q  <= or_acc_q  | (|in_);
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q   <= 5'd0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state_q   <= ACCUM;
                        and_acc_q <= 1'b1;
                        or_acc_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    // Handshake flags depend only on the registered state.
    // Results are forced to 0 outside DONE.
    assign in_rdy   = (state_q == ACCUM);
    assign out_val  = (state_q == DONE);
    assign out_and  = out_val &  and_acc_q;
    assign out_nand = out_val & ~and_acc_q;
    assign out_or   = out_val &  or_acc_q;
    assign out_nor  = out_val & ~or_acc_q;
`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
    assign out_count = out_val ? cnt_acc_q : 7'd0;
`endif

endmodule

// File: tb/tb_serial_gates_100_reduce.sv
// Directed self-checking bench for serial_gates_100_reduce.
// Checks out_count only when SERIAL_GATES_100_REDUCE_COUNT_EN is defined.
module tb_serial_gates_100_reduce;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_;
    logic       out_val;
    logic       out_rdy;
    logic       out_and;
    logic       out_nand;
    logic       out_or;
    logic       out_nor;
`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
    logic [6:0] out_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    serial_gates_100_reduce dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_      (in_),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_and  (out_and),
        .out_nand (out_nand),
        .out_or   (out_or),
        .out_nor  (out_nor)
`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
        ,
        .out_count(out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for in_rdy; a timeout counts as a failed comparison.
    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (in_rdy !== 1'b1) begin
            if (n > 100) begin
                chk({tag, "_rdy_timeout"}, 32'd0, 32'd1);
                break;
            end
            tick();
            n++;
        end
    endtask

    // Send a 100-bit operand as 25 beats.
    // With gap set, in_val drops for one cycle between beats.
    // Returns 1 time unit after the edge that accepts beat 24.
    task automatic send_operand(input string tag, input logic [99:0] op, input bit gap);
        for (int k = 0; k < 25; k++) begin
            wait_rdy(tag);
            in_val = 1'b1;
            in_    = op[4*k +: 4];
            tick();
            in_val = 1'b0;
            if (gap && k < 24) begin
                in_ = 4'h0;
                tick();
            end
        end
        in_ = 4'h0;
    endtask

    // Check the full result set as presented in DONE.
    task automatic check_results(input string tag, input bit e_and, input bit e_or,
                                 input int e_cnt);
        chk({tag, "_out_val"},  32'(out_val),  32'd1);
        chk({tag, "_in_rdy"},   32'(in_rdy),   32'd0);
        chk({tag, "_and"},      32'(out_and),  32'(e_and));
        chk({tag, "_nand"},     32'(out_nand), 32'(!e_and));
        chk({tag, "_or"},       32'(out_or),   32'(e_or));
        chk({tag, "_nor"},      32'(out_nor),  32'(!e_or));
`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
        chk({tag, "_count"},    32'(out_count), 32'(e_cnt));
`else
        if (e_cnt < 0) $display("note %s: negative count", tag);
`endif
    endtask

    // Check the idle state in ACCUM: ready for input, no results, outputs zero.
    task automatic check_idle(input string tag);
        chk({tag, "_out_val"}, 32'(out_val), 32'd0);
        chk({tag, "_in_rdy"},  32'(in_rdy),  32'd1);
        chk({tag, "_zeros"},   32'({out_and, out_nand, out_or, out_nor}), 32'd0);
`ifdef SERIAL_GATES_100_REDUCE_COUNT_EN
        chk({tag, "_count0"},  32'(out_count), 32'd0);
`endif
    endtask

    logic [99:0] op;

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_     = 4'h0;
        out_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");

        // All zeros, back-to-back.
        out_rdy = 1'b1;
        send_operand("zeros", 100'h0, 1'b0);
        check_results("zeros", 1'b0, 1'b0, 0);
        tick();
        check_idle("zeros_after");

        // All ones: count 100.
        send_operand("ones", {100{1'b1}}, 1'b0);
        check_results("ones", 1'b1, 1'b1, 100);
        tick();

        // Only bit 99 set (beat 24 = 0x8).
        op = 100'h0;
        op[99] = 1'b1;
        send_operand("bit99", op, 1'b0);
        check_results("bit99", 1'b0, 1'b1, 1);
        tick();

        // 0x8_deadbeef x3 with bubbles between beats.
        // Popcount is 3*24 + 1 = 73.
        op = {4'h8, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef};
        send_operand("beef_gap", op, 1'b1);
        check_results("beef_gap", 1'b0, 1'b1, 73);
        tick();

        // Backpressure: hold out_rdy low. Offer beats in DONE; they are ignored.
        // Operand 0xf1 has popcount 5.
        out_rdy = 1'b0;
        send_operand("hold", 100'hf1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            in_val = 1'b1;
            in_    = 4'hf;
            tick();
            check_results($sformatf("hold_c%0d", c), 1'b0, 1'b1, 5);
        end
        in_val  = 1'b0;
        in_     = 4'h0;
        out_rdy = 1'b1;
        tick();
        check_idle("hold_xfer");
        send_operand("after_hold", 100'h0, 1'b0);
        check_results("after_hold", 1'b0, 1'b0, 0);
        tick();

        // Partial operand of 0xf beats, then a 1-cycle reset pulse.
        for (int k = 0; k < 10; k++) begin
            in_val = 1'b1;
            in_    = 4'hf;
            tick();
        end
        in_val = 1'b0;
        in_    = 4'h0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        check_idle("mid_reset");
        send_operand("post_reset", 100'h0, 1'b0);
        check_results("post_reset", 1'b0, 1'b0, 0);
        tick();
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
